// File: rtl/bwt_pkg.sv
// Shared types and constants for the BWT prefix-doubling sorter stages.
package bwt_pkg;

  typedef logic [7:0] byte_t;

  // One key triple: [2]=string index, [1]=bucket, [0]=offset-bucket.
  typedef byte_t [2:0] key_t;

  localparam int unsigned KEY_IDX = 2;
  localparam int unsigned KEY_B1  = 1;
  localparam int unsigned KEY_B0  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rebucket_keys_if.sv
// Bus between the sorter controller and the rebucketing stage.
interface rebucket_keys_if
  import bwt_pkg::*;
#(
  parameter int unsigned STRING_LEN = 8
);

  logic                          start;
  key_t  [0:STRING_LEN-1]        keys_in;
  byte_t [0:STRING_LEN-1]        buckets_out;
  byte_t                         num_ranks;
  logic                          all_unique;
  logic                          idx_err;
  logic                          done;

  modport master (
    output start, keys_in,
    input  buckets_out, num_ranks, all_unique, idx_err, done
  );

  modport slave (
    input  start, keys_in,
    output buckets_out, num_ranks, all_unique, idx_err, done
  );

endinterface

// File: rtl/rebucket_keys.sv
// Scans a sorted key array one key per cycle and assigns dense bucket ranks.
module rebucket_keys
  import bwt_pkg::*;
#(
  parameter int unsigned STRING_LEN = 8
) (
  input logic             clk,
  input logic             rst,
  rebucket_keys_if.slave  bus
);

  localparam byte_t LEN_B  = byte_t'(STRING_LEN);
  localparam byte_t LAST_B = byte_t'(STRING_LEN - 1);

  state_e                  state_q, state_d;
  byte_t                   counter_q;
  byte_t                   rank_q;
  byte_t                   prev_b1_q, prev_b0_q;
  key_t  [0:STRING_LEN-1]  key_reg_q;
  byte_t [0:STRING_LEN-1]  buckets_q;
  byte_t                   num_ranks_q;
  logic                    all_unique_q;
  logic                    idx_err_q;

  logic  accept;
  key_t  cur_key;
  logic  new_group;
  byte_t rank_n;
  logic  idx_ok;
  logic  last_key;

  assign accept = bus.start && (state_q == IDLE || state_q == DONE);

  // Select the current key and derive its rank and index validity.
  always_comb begin
    cur_key = '0;
    for (int i = 0; i < STRING_LEN; i++) begin
      if (counter_q == byte_t'(i)) cur_key = key_reg_q[i];
    end
    new_group = (counter_q == 8'd0) ||
                ({cur_key[KEY_B1], cur_key[KEY_B0]} != {prev_b1_q, prev_b0_q});
    rank_n    = new_group ? rank_q + 8'd1 : rank_q;
    idx_ok    = cur_key[KEY_IDX] < LEN_B;
    last_key  = counter_q == LAST_B;
  end

  // Next-state logic; illegal encodings fall back to IDLE.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = bus.start ? SCAN : IDLE;
      SCAN:    state_d = last_key ? DONE : SCAN;
      DONE:    state_d = bus.start ? SCAN : DONE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: latch keys on accept, then rank one key per edge while scanning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_q    <= '0;
      rank_q       <= '0;
      prev_b1_q    <= '0;
      prev_b0_q    <= '0;
      key_reg_q    <= '0;
      buckets_q    <= '0;
      num_ranks_q  <= '0;
      all_unique_q <= 1'b0;
      idx_err_q    <= 1'b0;
    end else if (accept) begin
      key_reg_q    <= bus.keys_in;
      counter_q    <= '0;
      rank_q       <= '0;
      prev_b1_q    <= '0;
      prev_b0_q    <= '0;
      buckets_q    <= '0;
      num_ranks_q  <= '0;
      all_unique_q <= 1'b0;
      idx_err_q    <= 1'b0;
    end else if (state_q == SCAN) begin
      // Duplicate indices: the later key simply overwrites the slot.
      for (int i = 0; i < STRING_LEN; i++) begin
        if (idx_ok && cur_key[KEY_IDX] == byte_t'(i)) buckets_q[i] <= rank_n;
      end
      if (!idx_ok) idx_err_q <= 1'b1;
      rank_q    <= rank_n;
      prev_b1_q <= cur_key[KEY_B1];
      prev_b0_q <= cur_key[KEY_B0];
      counter_q <= counter_q + 8'd1;
      if (last_key) begin
        num_ranks_q  <= rank_n;
        all_unique_q <= rank_n == LEN_B;
      end
    end
  end

  assign bus.buckets_out = buckets_q;
  assign bus.num_ranks   = num_ranks_q;
  assign bus.all_unique  = all_unique_q;
  assign bus.idx_err     = idx_err_q;
  assign bus.done        = state_q == DONE;

endmodule

// File: tb/tb_rebucket_keys.sv
// Directed self-checking bench for rebucket_keys with STRING_LEN = 8.
module tb_rebucket_keys;
  import bwt_pkg::*;

  localparam int unsigned N = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rebucket_keys_if #(.STRING_LEN(N)) bus ();

  rebucket_keys #(.STRING_LEN(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  key_t  [0:N-1] k_distinct, k_equal, k_mixed, k_bad;
  byte_t [0:N-1] e_distinct, e_equal, e_mixed, e_bad;

  function automatic key_t mk(input int idx, input int b1, input int b0);
    key_t k;
    k[KEY_IDX] = byte_t'(idx);
    k[KEY_B1]  = byte_t'(b1);
    k[KEY_B0]  = byte_t'(b0);
    return k;
  endfunction

  // Pulse start across one rising edge; returns at the negedge after it.
  task automatic pulse_start(input key_t [0:N-1] keys);
    bus.keys_in = keys;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Count negedges until done rises, bounded at 40.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic check_result(input string name, input byte_t [0:N-1] eb, input byte_t enr,
                              input logic eu, input logic ee);
    checks++;
    if (bus.buckets_out !== eb) begin
      errors++;
      $display("FAIL %s buckets got %h want %h", name, bus.buckets_out, eb);
    end
    checks++;
    if (bus.num_ranks !== enr) begin
      errors++;
      $display("FAIL %s num_ranks got %0d want %0d", name, bus.num_ranks, enr);
    end
    checks++;
    if (bus.all_unique !== eu) begin
      errors++;
      $display("FAIL %s all_unique got %b want %b", name, bus.all_unique, eu);
    end
    checks++;
    if (bus.idx_err !== ee) begin
      errors++;
      $display("FAIL %s idx_err got %b want %b", name, bus.idx_err, ee);
    end
  endtask

  task automatic run_and_check(input string name, input key_t [0:N-1] keys,
                               input byte_t [0:N-1] eb, input byte_t enr,
                               input logic eu, input logic ee);
    int cyc;
    pulse_start(keys);
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL %s latency got %0d want 8", name, cyc);
    end
    check_result(name, eb, enr, eu, ee);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.done !== 1'b0 || bus.buckets_out !== '0 || bus.num_ranks !== 8'd0 ||
        bus.all_unique !== 1'b0 || bus.idx_err !== 1'b0) begin
      errors++;
      $display("FAIL reset got done=%b b=%h nr=%0d u=%b e=%b want all 0", bus.done,
               bus.buckets_out, bus.num_ranks, bus.all_unique, bus.idx_err);
    end
  endtask

  task automatic test_distinct();
    run_and_check("distinct", k_distinct, e_distinct, 8'd8, 1'b1, 1'b0);
    // Outputs hold while idle in DONE.
    repeat (3) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.buckets_out !== e_distinct) begin
      errors++;
      $display("FAIL hold got done=%b b=%h want 1 %h", bus.done, bus.buckets_out, e_distinct);
    end
  endtask

  task automatic test_all_equal();
    run_and_check("equal", k_equal, e_equal, 8'd1, 1'b0, 1'b0);
  endtask

  task automatic test_mixed();
    run_and_check("mixed", k_mixed, e_mixed, 8'd5, 1'b0, 1'b0);
  endtask

  task automatic test_bad_index();
    run_and_check("bad_idx", k_bad, e_bad, 8'd5, 1'b0, 1'b1);
    run_and_check("clean_after_bad", k_mixed, e_mixed, 8'd5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    pulse_start(k_distinct);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.buckets_out !== '0 || bus.num_ranks !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst got done=%b b=%h nr=%0d want 0", bus.done, bus.buckets_out,
               bus.num_ranks);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.buckets_out !== '0) begin
      errors++;
      $display("FAIL post_rst_idle got done=%b b=%h want 0", bus.done, bus.buckets_out);
    end
    run_and_check("after_rst", k_mixed, e_mixed, 8'd5, 1'b0, 1'b0);
  endtask

  task automatic test_start_handling();
    int cyc;
    // Keys change right after the accept edge; a stray start lands mid-scan.
    pulse_start(k_distinct);
    bus.keys_in = k_equal;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      bus.start = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL ignore_start latency got %0d want 8", cyc);
    end
    check_result("latched_keys", e_distinct, 8'd8, 1'b1, 1'b0);
    // Restart from DONE clears buckets on the accept edge.
    pulse_start(k_mixed);
    checks++;
    if (bus.done !== 1'b0 || bus.buckets_out !== '0 || bus.all_unique !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear got done=%b b=%h u=%b want 0", bus.done, bus.buckets_out,
               bus.all_unique);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL restart latency got %0d want 8", cyc);
    end
    check_result("restart", e_mixed, 8'd5, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    k_distinct = {mk(4,1,0), mk(0,1,2), mk(6,2,0), mk(1,2,3),
                  mk(3,3,1), mk(7,4,0), mk(2,5,5), mk(5,6,0)};
    e_distinct = {8'd2, 8'd4, 8'd7, 8'd5, 8'd1, 8'd8, 8'd3, 8'd6};
    for (int i = 0; i < N; i++) begin
      k_equal[i] = mk(i, 1, 1);
      e_equal[i] = 8'd1;
    end
    k_mixed = {mk(3,1,2), mk(5,1,2), mk(0,1,3), mk(7,2,0),
               mk(1,2,1), mk(2,2,1), mk(4,3,0), mk(6,3,0)};
    e_mixed = {8'd2, 8'd4, 8'd4, 8'd1, 8'd5, 8'd1, 8'd5, 8'd3};
    k_bad = k_mixed;
    k_bad[3] = mk(9, 2, 0);
    e_bad = {8'd2, 8'd4, 8'd4, 8'd1, 8'd5, 8'd1, 8'd5, 8'd0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.keys_in = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();

    test_distinct();
    test_all_equal();
    test_mixed();
    test_bad_index();
    test_reset_mid_scan();
    test_start_handling();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
